instr_fetch_unit: RTL and testbench
===================================

// Module: instr_fetch_unit
// PURPOSE
//  Front end of the multi-cycle CPU: owns the PC, issues word fetches to instruction memory over a
//  req/ack handshake and buffers returned words in a small FIFO. Presents {instruction, PC} to the
//  decode/execute FSM over a valid/ready handshake. Supports redirect (branch/jump) with flush.
// PARAMETERS
//  PC_W        10     PC / byte-address width; PC advances by 4 and wraps mod 2^PC_W
//  INST_W      32     instruction word width
//  RESET_PC    0      PC after reset; low 2 bits must be 0
//  FIFO_DEPTH  2      instruction buffer entries; power of two, >=2
// PORTS
//  clk             in   1       rising-edge clock
//  rst_n           in   1       synchronous active-low reset
//  imem_req        out  1       fetch request; held with imem_addr stable until imem_ack
//  imem_addr       out  PC_W    byte address of word being fetched, [1:0]==0
//  imem_ack        in   1       request complete; imem_rdata valid this cycle (0+ wait states)
//  imem_rdata      in   INST_W  fetched word
//  inst_valid      out  1       FIFO head valid
//  inst_ready      in   1       consumer takes head when valid&ready
//  inst_data       out  INST_W  head instruction
//  inst_pc         out  PC_W    head instruction address
//  redirect_valid  in   1       flush and refetch from redirect_pc (1-cycle pulse)
//  redirect_pc     in   PC_W    new PC; bits [1:0] ignored (forced 0)
//  stall_cnt       out  16      only with IFU_STALL_CNT_EN (see CONFIGURATION)
// BEHAVIOUR
//  Reset (rst_n==0 at posedge): pc=RESET_PC, state=IDLE, FIFO empty, imem_req=0, inst_valid=0,
//   imem_addr=RESET_PC, inst_data/inst_pc=0, stall_cnt=0. Any in-flight response is dropped.
//  FSM states: IDLE, REQ, DISCARD.
//   IDLE: if (fifo_count + 0) < FIFO_DEPTH -> REQ with imem_req=1, imem_addr=pc next cycle.
//   REQ: imem_req=1. On imem_ack: push {imem_rdata,pc}, pc<=pc+4; stay REQ if count after push
//    < FIFO_DEPTH (back-to-back, no bubble), else IDLE.
//   DISCARD: imem_req stays 1 at old addr until imem_ack; response dropped; then REQ at pc.
//  Never more than one outstanding request; request only issued when a FIFO slot is free, so
//   push into full FIFO cannot occur.
//  Latency: first imem_req in cycle after rst_n sampled high; inst_valid rises the cycle after the
//   ack; zero-wait memory sustains 1 instruction/cycle when consumer always ready.
//  Pop on inst_valid&inst_ready; simultaneous push+pop leaves count unchanged.
//  Redirect (sampled at posedge): FIFO flushed, pc<={redirect_pc[PC_W-1:2],2'b00}.
//   In REQ without ack same cycle -> DISCARD. In REQ with ack same cycle -> that data dropped,
//   next state REQ at new pc. In IDLE/DISCARD -> REQ / stay DISCARD with new pc.
//   Redirect overrides a same-cycle pop; inst_valid=0 the following cycle.
//  PC increment wraps: pc=2^PC_W-4 -> 0.
// CONFIGURATION
//  IFU_STALL_CNT_EN defined: stall_cnt port present; increments each cycle inst_valid==0 and
//   rst_n==1, saturates at 16'hFFFF, cleared only by reset.
//  Not defined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Shared header cpu_defs.vh: stage/opcode/funct constants, INST_W, PC_W, IFU state encodings
//   (IFU_IDLE, IFU_REQ, IFU_DISCARD).
//  Sub-module ifu_fifo: sync FIFO (WIDTH=INST_W+PC_W, DEPTH), flush input, count output.
//  Top holds PC register, FSM, redirect logic, optional counter.
// TESTING
//  Zero-wait mem, ready=1, RESET_PC=0 -> pcs 0,4,8,C on consecutive cycles; first valid 2 cycles
//   after reset release.
//  ready=0, 3 wait states -> exactly 2 fetches (0,4), imem_req low after, inst_pc=0 held stable.
//  Redirect to 0x40 during wait state of fetch 0x8 -> 0x8 data dropped, next inst_pc=0x40.
//  Redirect to 0x23 same cycle as ack -> acked word dropped, next fetch addr 0x20.
//  pc=0x3FC, PC_W=10 -> next fetch addr 0x000.
//  rst_n low mid-REQ -> next cycle imem_req=0, inst_valid=0; IFU_STALL_CNT_EN: stall_cnt=0.

Source files
------------

// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and default sizes for the instruction fetch unit.
package instr_fetch_unit_pkg;

  localparam int IFU_PC_W       = 10;
  localparam int IFU_INST_W     = 32;
  localparam int IFU_FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IFU_IDLE    = 2'd0,
    IFU_REQ     = 2'd1,
    IFU_DISCARD = 2'd2
  } ifu_state_t;

endpackage

// File: rtl/instr_fetch_unit_fifo.sv
// Synchronous instruction buffer with flush; flush takes priority over push/pop.
module instr_fetch_unit_fifo
  import instr_fetch_unit_pkg::*;
#(
  parameter int WIDTH = IFU_INST_W + IFU_PC_W,
  parameter int DEPTH = IFU_FIFO_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  // Storage, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch front end: PC, single-outstanding imem request FSM, redirect/flush, instruction buffer.
// Optional stall counter output enabled by defining IFU_STALL_CNT_EN.
module instr_fetch_unit
  import instr_fetch_unit_pkg::*;
#(
  parameter int              PC_W       = IFU_PC_W,
  parameter int              INST_W     = IFU_INST_W,
  parameter logic [PC_W-1:0] RESET_PC   = '0,
  parameter int              FIFO_DEPTH = IFU_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [PC_W-1:0]   inst_pc,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc
`ifdef IFU_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  ifu_state_t             state_r;
  logic [PC_W-1:0]        pc_r;
  logic [PC_W-1:0]        pc_inc_s;
  logic [PC_W-1:0]        redir_pc_s;
  logic [CW-1:0]          fifo_count;
  logic [CW-1:0]          cnt_next_s;
  logic                   push_s;
  logic                   pop_s;
  logic [INST_W+PC_W-1:0] head_s;
  logic                   unused_s;

  assign pc_inc_s   = pc_r + PC_W'(4);
  assign redir_pc_s = {redirect_pc[PC_W-1:2], 2'b00};
  assign unused_s   = ^redirect_pc[1:0];

  // A response that lands in the redirect cycle belongs to the old stream and is dropped.
  assign push_s     = (state_r == IFU_REQ) && imem_ack && !redirect_valid;
  assign pop_s      = inst_valid && inst_ready;
  assign inst_valid = (fifo_count != '0);
  assign inst_data  = head_s[PC_W +: INST_W];
  assign inst_pc    = head_s[PC_W-1:0];

  // Occupancy after this cycle's push/pop, used to decide on a back-to-back request.
  always_comb begin
    cnt_next_s = fifo_count + CW'(push_s) - CW'(pop_s);
  end

  instr_fetch_unit_fifo #(
    .WIDTH (INST_W + PC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push_s),
    .push_data ({imem_rdata, pc_r}),
    .pop       (pop_s),
    .pop_data  (head_s),
    .count     (fifo_count)
  );

  // Fetch FSM with registered request/address outputs and PC update.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IFU_IDLE;
      pc_r      <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      case (state_r)
        IFU_IDLE: begin
          if (redirect_valid) begin
            pc_r      <= redir_pc_s;
            imem_addr <= redir_pc_s;
            imem_req  <= 1'b1;
            state_r   <= IFU_REQ;
          end else if (fifo_count < CW'(FIFO_DEPTH)) begin
            imem_addr <= pc_r;
            imem_req  <= 1'b1;
            state_r   <= IFU_REQ;
          end else begin
            state_r   <= IFU_IDLE;
          end
        end
        IFU_REQ: begin
          if (redirect_valid) begin
            pc_r <= redir_pc_s;
            if (imem_ack) begin
              imem_addr <= redir_pc_s;
              state_r   <= IFU_REQ;
            end else begin
              state_r   <= IFU_DISCARD;
            end
          end else if (imem_ack) begin
            pc_r <= pc_inc_s;
            if (cnt_next_s < CW'(FIFO_DEPTH)) begin
              imem_addr <= pc_inc_s;
              state_r   <= IFU_REQ;
            end else begin
              imem_req  <= 1'b0;
              state_r   <= IFU_IDLE;
            end
          end else begin
            state_r <= IFU_REQ;
          end
        end
        IFU_DISCARD: begin
          // Old request must complete on the bus before the new stream starts.
          if (redirect_valid) begin
            pc_r <= redir_pc_s;
          end
          if (imem_ack) begin
            imem_addr <= redirect_valid ? redir_pc_s : pc_r;
            state_r   <= IFU_REQ;
          end else begin
            state_r   <= IFU_DISCARD;
          end
        end
        default: begin
          imem_req <= 1'b0;
          state_r  <= IFU_IDLE;
        end
      endcase
    end
  end

`ifdef IFU_STALL_CNT_EN
  // Cycles with no instruction offered to decode; saturating.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= 16'h0000;
    end else if (!inst_valid && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios plus randomized run vs. stream model.
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [9:0]  inst_pc;
  logic        redirect_valid;
  logic [9:0]  redirect_pc;
`ifdef IFU_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  int          fixed_wait = 0;
  int          wait_left = 0;
  bit          busy = 1'b0;
  logic [9:0]  start_addr = 10'h000;
  logic [9:0]  ack_q[$];

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef IFU_STALL_CNT_EN
    ,
    .stall_cnt      (stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [9:0] a);
    return {6'h2B, ~a, 6'h15, a};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 10'h000;
    repeat (3) tick();
    ack_q.delete();
    rst_n = 1'b1;
  endtask

  // Memory model: wait states then a one-cycle ack; address must stay put while pending.
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = 32'h0000_0000;
    forever begin
      @(negedge clk);
      imem_ack = 1'b0;
      if (rst_n && imem_req) begin
        if (!busy) begin
          busy       = 1'b1;
          start_addr = imem_addr;
          wait_left  = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        end
        if (wait_left == 0) begin
          check_eq("mem_addr_stable", 32'(imem_addr), 32'(start_addr));
          imem_ack   = 1'b1;
          imem_rdata = mem_word(imem_addr);
          busy       = 1'b0;
          ack_q.push_back(imem_addr);
        end else begin
          wait_left--;
        end
      end else begin
        busy = 1'b0;
      end
    end
  end

  initial begin
    logic [9:0] pq[$];
    logic [9:0] wexp[4];
    logic [9:0] exp_pc;
    logic [9:0] a0;
    logic [9:0] a1;
    int         stall_model;
    int         pops;
    bit         exp_invalid;
    bit         found;

    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 10'h000;

    // Reset state
    fixed_wait = 0;
    do_reset();
    rst_n = 1'b0;
    tick();
    check_eq("rst_req", 32'(imem_req), 32'd0);
    check_eq("rst_valid", 32'(inst_valid), 32'd0);
    check_eq("rst_addr", 32'(imem_addr), 32'd0);
    check_eq("rst_pc", 32'(inst_pc), 32'd0);
    check_eq("rst_data", inst_data, 32'd0);
`ifdef IFU_STALL_CNT_EN
    check_eq("rst_stall", 32'(stall_cnt), 32'd0);
`endif

    // Zero-wait streaming with consumer always ready
    do_reset();
    inst_ready = 1'b1;
    tick();
    check_eq("t2_first_req", 32'(imem_req), 32'd1);
    check_eq("t2_first_addr", 32'(imem_addr), 32'd0);
    check_eq("t2_valid_early", 32'(inst_valid), 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check_eq("t2_valid", 32'(inst_valid), 32'd1);
      check_eq("t2_pc", 32'(inst_pc), 32'(i * 4));
      check_eq("t2_data", inst_data, mem_word(10'(i * 4)));
    end

    // Consumer stalled, 3 wait states: buffer fills then fetching stops
    fixed_wait = 3;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      tick();
      if (inst_valid) check_eq("t3_pc_hold", 32'(inst_pc), 32'd0);
    end
    check_eq("t3_nfetch", 32'(ack_q.size()), 32'd2);
    a0 = (ack_q.size() > 0) ? ack_q[0] : 10'h3FF;
    a1 = (ack_q.size() > 1) ? ack_q[1] : 10'h3FF;
    check_eq("t3_addr0", 32'(a0), 32'h0);
    check_eq("t3_addr1", 32'(a1), 32'h4);
    check_eq("t3_req_low", 32'(imem_req), 32'd0);
    check_eq("t3_valid", 32'(inst_valid), 32'd1);

    // Redirect during a wait state of the 0x8 fetch
    do_reset();
    inst_ready = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (imem_req && imem_addr == 10'h008 && !imem_ack) found = 1'b1;
    end
    check_eq("t4_reach_8", 32'(found), 32'd1);
    ack_q.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 10'h040;
    tick();
    redirect_valid = 1'b0;
    check_eq("t4_valid_flushed", 32'(inst_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (inst_valid) found = 1'b1;
      else tick();
    end
    check_eq("t4_valid_seen", 32'(found), 32'd1);
    check_eq("t4_pc", 32'(inst_pc), 32'h40);
    check_eq("t4_data", inst_data, mem_word(10'h040));
    a0 = (ack_q.size() > 0) ? ack_q[0] : 10'h3FF;
    a1 = (ack_q.size() > 1) ? ack_q[1] : 10'h3FF;
    check_eq("t4_old_ack", 32'(a0), 32'h8);
    check_eq("t4_new_ack", 32'(a1), 32'h40);

    // Redirect to unaligned 0x23 in the same cycle as an ack
    fixed_wait = 2;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (imem_ack && imem_addr == 10'h004) found = 1'b1;
    end
    check_eq("t5_reach_ack4", 32'(found), 32'd1);
    ack_q.delete();
    redirect_valid = 1'b1;
    redirect_pc    = 10'h023;
    tick();
    redirect_valid = 1'b0;
    check_eq("t5_valid_flushed", 32'(inst_valid), 32'd0);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      if (inst_valid) found = 1'b1;
      else tick();
    end
    check_eq("t5_valid_seen", 32'(found), 32'd1);
    check_eq("t5_pc", 32'(inst_pc), 32'h20);
    a0 = (ack_q.size() > 0) ? ack_q[0] : 10'h3FF;
    check_eq("t5_next_fetch", 32'(a0), 32'h20);

    // PC wrap at the top of the address space
    fixed_wait = 0;
    do_reset();
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 10'h3F8;
    inst_ready     = 1'b1;
    tick();
    redirect_valid = 1'b0;
    pq.delete();
    for (int i = 0; i < 40 && pq.size() < 4; i++) begin
      if (inst_valid && inst_ready) pq.push_back(inst_pc);
      tick();
    end
    wexp = '{10'h3F8, 10'h3FC, 10'h000, 10'h004};
    for (int i = 0; i < 4; i++) begin
      check_eq("t6_wrap_pc", (i < pq.size()) ? 32'(pq[i]) : 32'hFFFF_FFFF, 32'(wexp[i]));
    end

    // Reset asserted while a request is pending
    fixed_wait = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      if (imem_req && imem_addr == 10'h004) found = 1'b1;
    end
    check_eq("t7_reach_req", 32'(found), 32'd1);
    rst_n = 1'b0;
    tick();
    check_eq("t7_req_low", 32'(imem_req), 32'd0);
    check_eq("t7_valid_low", 32'(inst_valid), 32'd0);
`ifdef IFU_STALL_CNT_EN
    check_eq("t7_stall_zero", 32'(stall_cnt), 32'd0);
`endif

    // Randomized run against an in-order instruction stream model
    fixed_wait = -1;
    do_reset();
    exp_pc      = 10'h000;
    stall_model = 1;
    pops        = 0;
    exp_invalid = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (exp_invalid) check_eq("rnd_valid_after_redirect", 32'(inst_valid), 32'd0);
      exp_invalid = 1'b0;
      stall_model += inst_valid ? 0 : 1;
      inst_ready     = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      redirect_pc    = 10'($urandom);
      if (redirect_valid) begin
        exp_pc      = {redirect_pc[9:2], 2'b00};
        exp_invalid = 1'b1;
      end else if (inst_valid && inst_ready) begin
        check_eq("rnd_pc", 32'(inst_pc), 32'(exp_pc));
        check_eq("rnd_data", inst_data, mem_word(exp_pc));
        exp_pc = exp_pc + 10'd4;
        pops++;
      end
    end
    tick();
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    check_eq("rnd_progress", 32'(pops >= 300), 32'd1);
`ifdef IFU_STALL_CNT_EN
    check_eq("rnd_stall_cnt", 32'(stall_cnt), 32'(stall_model));
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
